eggnet_cfg_sequencer: RTL

AXI4-Lite master that programs the EggNet S00_AXI register bank from a parallel configuration vector and, optionally, reads every register back and compares it. It sits between the network control logic and the EggNet slave port. It replaces the manual write/read-back sequence with one start pulse and reports done/error status.

---
 rtl/eggnet_cfg_pkg.sv | 21 ++
 rtl/eggnet_cfg_timeout.sv | 29 ++
 rtl/eggnet_cfg_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eggnet_cfg_pkg.sv
// Shared types and constants for the EggNet configuration sequencer.
package eggnet_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RESP     = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/eggnet_cfg_timeout.sv
// Handshake watchdog: counts waiting cycles and flags expiry on the
// C_TIMEOUT-th consecutive waiting cycle of a state.
module eggnet_cfg_timeout #(
  parameter int C_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(C_TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  assign expire = enable && (count_reg == CW'(C_TIMEOUT - 1));

  // Wait counter, restarted on every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else if (clear)
      count_reg <= '0;
    else if (enable && !expire)
      count_reg <= count_reg + 1'b1;
  end

endmodule

// File: rtl/eggnet_cfg_sequencer.sv
// AXI4-Lite master that writes a configuration vector into the EggNet
// register bank, optionally reads it back, and reports done/error status.
module eggnet_cfg_sequencer
  import eggnet_cfg_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS       = 4,
  parameter int C_BASE_ADDR      = 0,
  parameter int C_TIMEOUT        = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  input  logic                          verify_en,
  input  logic [C_NUM_REGS*32-1:0]      cfg_data,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    err_code,
  output logic [3:0]                    err_index,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

  state_t                        state_reg, state_next;
  logic [3:0]                    idx_reg, idx_next;
  logic                          verify_reg;
  logic [C_AXI_DATA_WIDTH-1:0]   shadow_reg [16];
  logic [C_AXI_DATA_WIDTH-1:0]   cfg_word [16];
  logic                          load_shadow;
  logic                          awvalid_reg, awvalid_next;
  logic                          wvalid_reg, wvalid_next;
  logic                          arvalid_reg, arvalid_next;
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic [C_AXI_ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [1:0]                    err_code_reg, err_code_next;
  logic [3:0]                    err_index_reg, err_index_next;
  logic                          tmo_expire;

  function automatic logic [C_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
    return C_AXI_ADDR_WIDTH'(C_BASE_ADDR + 4 * int'(i));
  endfunction

  // Unpack the flat configuration vector; unused slots read as zero
  for (genvar gi = 0; gi < 16; gi++) begin : g_cfg_word
    if (gi < C_NUM_REGS) begin : g_used
      assign cfg_word[gi] = cfg_data[gi*32 +: 32];
    end else begin : g_unused
      assign cfg_word[gi] = '0;
    end
  end

  assign busy          = (state_reg == WR_ADDR_DATA) || (state_reg == WR_RESP) ||
                         (state_reg == RD_ADDR) || (state_reg == RD_DATA);
  assign done          = (state_reg == FINISH);
  assign M_AXI_BREADY  = (state_reg == WR_RESP);
  assign M_AXI_RREADY  = (state_reg == RD_DATA);
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign err_code      = err_code_reg;
  assign err_index     = err_index_reg;

  // Every state that is busy has at least one valid or ready outstanding
  eggnet_cfg_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_timeout (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .clear  (state_next != state_reg),
    .enable (busy),
    .expire (tmo_expire)
  );

  // Shadow copy of the configuration, captured when a sequence is accepted
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      verify_reg <= 1'b0;
      for (int i = 0; i < 16; i++) shadow_reg[i] <= '0;
    end else if (load_shadow) begin
      verify_reg <= verify_en;
      for (int i = 0; i < 16; i++) shadow_reg[i] <= cfg_word[i];
    end
  end

  // State, index, AXI drive and status registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      err_code_reg  <= ERR_NONE;
      err_index_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      arvalid_reg   <= arvalid_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      err_code_reg  <= err_code_next;
      err_index_reg <= err_index_next;
    end
  end

  // Next-state and next-drive logic; first error aborts to FINISH
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    awaddr_next    = awaddr_reg;
    araddr_next    = araddr_reg;
    wdata_next     = wdata_reg;
    err_code_next  = err_code_reg;
    err_index_next = err_index_reg;
    load_shadow    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          load_shadow    = 1'b1;
          err_code_next  = ERR_NONE;
          err_index_next = '0;
          idx_next       = '0;
          awvalid_next   = 1'b1;
          wvalid_next    = 1'b1;
          awaddr_next    = reg_addr(4'd0);
          wdata_next     = cfg_word[0];
          state_next     = WR_ADDR_DATA;
        end
      end
      WR_ADDR_DATA: begin
        if (awvalid_reg && M_AXI_AWREADY) awvalid_next = 1'b0;
        if (wvalid_reg && M_AXI_WREADY)   wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) begin
          state_next = WR_RESP;
        end else if (tmo_expire) begin
          awvalid_next   = 1'b0;
          wvalid_next    = 1'b0;
          err_code_next  = ERR_TIMEOUT;
          err_index_next = idx_reg;
          state_next     = FINISH;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_code_next  = ERR_RESP;
            err_index_next = idx_reg;
            state_next     = FINISH;
          end else if (idx_reg != LAST_IDX) begin
            idx_next     = idx_reg + 4'd1;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            awaddr_next  = reg_addr(idx_next);
            wdata_next   = shadow_reg[idx_next];
            state_next   = WR_ADDR_DATA;
          end else if (verify_reg) begin
            idx_next     = '0;
            arvalid_next = 1'b1;
            araddr_next  = reg_addr(4'd0);
            state_next   = RD_ADDR;
          end else begin
            state_next = FINISH;
          end
        end else if (tmo_expire) begin
          err_code_next  = ERR_TIMEOUT;
          err_index_next = idx_reg;
          state_next     = FINISH;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_next = 1'b0;
          state_next   = RD_DATA;
        end else if (tmo_expire) begin
          arvalid_next   = 1'b0;
          err_code_next  = ERR_TIMEOUT;
          err_index_next = idx_reg;
          state_next     = FINISH;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != RESP_OKAY) begin
            err_code_next  = ERR_RESP;
            err_index_next = idx_reg;
            state_next     = FINISH;
          end else if (M_AXI_RDATA != shadow_reg[idx_reg]) begin
            err_code_next  = ERR_MISMATCH;
            err_index_next = idx_reg;
            state_next     = FINISH;
          end else if (idx_reg != LAST_IDX) begin
            idx_next     = idx_reg + 4'd1;
            arvalid_next = 1'b1;
            araddr_next  = reg_addr(idx_next);
            state_next   = RD_ADDR;
          end else begin
            state_next = FINISH;
          end
        end else if (tmo_expire) begin
          err_code_next  = ERR_TIMEOUT;
          err_index_next = idx_reg;
          state_next     = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
